rf_sequencer: RTL and testbench

Sequencing controller for the 8x4-bit register file. It accepts 12-bit register-to-register instructions over a valid/ready handshake. For each instruction it drives the file's read addresses, waits out the file's one-cycle registered read, computes a 4-bit ALU result and issues the write-back. It sits between the instruction source (FSM or user-input decoder) and the register file, and is the file's only address/write-enable driver.

---
 rtl/rf_sequencer_pkg.sv | 44 ++++
 rtl/rf_alu.sv | 48 ++++
 rtl/rf_sequencer.sv | 127 ++++++++++++
 tb/tb_rf_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sequencer_pkg.sv
// rf_ctrl_pkg: shared definitions for the register-file sequencer and its ALU.
// Contents: width constants, instruction field positions, the opcode and
// controller state enums, and a helper that extracts the opcode field.
package rf_ctrl_pkg;

    localparam int DW = 4;
    localparam int AW = 3;
    localparam int IW = 12;

    localparam int OP_MSB   = 11;
    localparam int OP_LSB   = 9;
    localparam int DEST_MSB = 8;
    localparam int DEST_LSB = 6;
    localparam int SRC1_MSB = 5;
    localparam int SRC1_LSB = 3;
    localparam int SRC2_MSB = 2;
    localparam int SRC2_LSB = 0;
    // The LDI immediate overlaps the low bit of src1 and all of src2.
    localparam int IMM_MSB  = 3;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_MOV = 3'b110,
        OP_LDI = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic opcode_t get_opcode(input logic [IW-1:0] ins);
        return opcode_t'(ins[OP_MSB:OP_LSB]);
    endfunction

endpackage

// File: rtl/rf_alu.sv
// rf_alu: purely combinational 4-bit ALU used by the register-file sequencer.
// Ports:
//   op    - 3-bit opcode (rf_ctrl_pkg::opcode_t encoding)
//   a, b  - operands (register-file read data 1 and 2)
//   imm   - LDI immediate
//   y     - result word
//   carry - ADD carry-out / SUB borrow, 0 for all other ops
//   zero  - y == 0
module rf_alu
    import rf_ctrl_pkg::*;
(
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] y,
    output logic          carry,
    output logic          zero
);

    logic [DW:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (opcode_t'(op))
            OP_ADD: begin
                y     = sum[DW-1:0];
                carry = sum[DW];
            end
            OP_SUB: begin
                y     = a - b;
                carry = (a < b);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MOV:  y = a;
            OP_LDI:  y = imm;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/rf_sequencer.sv
// rf_sequencer: sequences one register-to-register instruction every four
// cycles into an 8x4 register file with a one-cycle registered read.
// Ports:
//   clk, reset           - clock and asynchronous active-low reset
//   in_valid, in_ready   - instruction handshake (ready only in IDLE)
//   instr                - {opcode, dest, src1, src2}; LDI immediate in [3:0]
//   RF_ad1, RF_ad2       - register-file read addresses
//   RF_wad, RF_we, RF_wd - register-file write port
//   RF_d1, RF_d2         - registered read data from the file
//   busy, done           - activity indicator and one-cycle retire pulse
//   result, carry, zero  - last ALU result and flags, registered
module rf_sequencer
    import rf_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] instr,
    output logic [AW-1:0] RF_ad1,
    output logic [AW-1:0] RF_ad2,
    output logic [AW-1:0] RF_wad,
    output logic          RF_we,
    output logic [DW-1:0] RF_wd,
    input  logic [DW-1:0] RF_d1,
    input  logic [DW-1:0] RF_d2,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);

    state_t        state;
    state_t        next_state;
    logic [IW-1:0] instr_q;
    opcode_t       op_q;
    logic [DW-1:0] alu_y;
    logic          alu_carry;
    logic          alu_zero;

    assign op_q = get_opcode(instr_q);

    rf_alu u_alu (
        .op    (instr_q[OP_MSB:OP_LSB]),
        .a     (RF_d1),
        .b     (RF_d2),
        .imm   (instr_q[IMM_MSB:IMM_LSB]),
        .y     (alu_y),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_valid) next_state = S_READ;
            S_READ:  next_state = S_EXEC;
            S_EXEC:  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Instruction latch and result/flag registers. The flags register at the
    // same edge that commits the write; a NOP leaves them untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                instr_q <= instr;
            end
            if (state == S_EXEC && op_q != OP_NOP) begin
                result <= alu_y;
                carry  <= alu_carry;
                zero   <= alu_zero;
            end
        end
    end

    // Register-file controls are gated by state so that, outside READ/EXEC,
    // a stale latched instruction never reaches the file.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        RF_ad1   = '0;
        RF_ad2   = '0;
        RF_wad   = '0;
        RF_we    = 1'b0;
        RF_wd    = '0;
        case (state)
            S_IDLE: in_ready = 1'b1;
            S_READ: begin
                busy   = 1'b1;
                RF_ad1 = instr_q[SRC1_MSB:SRC1_LSB];
                RF_ad2 = instr_q[SRC2_MSB:SRC2_LSB];
            end
            S_EXEC: begin
                busy   = 1'b1;
                RF_ad1 = instr_q[SRC1_MSB:SRC1_LSB];
                RF_ad2 = instr_q[SRC2_MSB:SRC2_LSB];
                RF_wad = instr_q[DEST_MSB:DEST_LSB];
                RF_wd  = alu_y;
                RF_we  = (op_q != OP_NOP);
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: directed self-checking bench for rf_sequencer with a
// behavioural 8x4 register file (registered read, write at clock edge).
module tb_rf_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] instr;
    logic [2:0]  RF_ad1;
    logic [2:0]  RF_ad2;
    logic [2:0]  RF_wad;
    logic        RF_we;
    logic [3:0]  RF_wd;
    logic [3:0]  RF_d1;
    logic [3:0]  RF_d2;
    logic        busy;
    logic        done;
    logic [3:0]  result;
    logic        carry;
    logic        zero;

    logic [3:0]  rfMem [8];
    logic        loadEn;

    int checks;
    int failures;
    int weCount;
    int doneCount;
    int acceptCount;
    int cycleCount;
    int lastAccept;
    int prevAccept;

    rf_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .RF_ad1   (RF_ad1),
        .RF_ad2   (RF_ad2),
        .RF_wad   (RF_wad),
        .RF_we    (RF_we),
        .RF_wd    (RF_wd),
        .RF_d1    (RF_d1),
        .RF_d2    (RF_d2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: preload r1=1, r2=2, r3=3, others 0.
    always @(posedge clk) begin
        if (loadEn) begin
            for (int i = 0; i < 8; i++) rfMem[i] <= 4'(i < 4 ? i : 0);
        end else if (RF_we) begin
            rfMem[RF_wad] <= RF_wd;
        end
        RF_d1 <= rfMem[RF_ad1];
        RF_d2 <= rfMem[RF_ad2];
    end

    // Event counters sampled with pre-edge values, as the DUT sees them.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        if (RF_we) weCount <= weCount + 1;
        if (done) doneCount <= doneCount + 1;
        if (in_valid && in_ready) begin
            acceptCount <= acceptCount + 1;
            prevAccept  <= lastAccept;
            lastAccept  <= cycleCount;
        end
    end

    function automatic logic [11:0] mkInstr(input logic [2:0] op, input logic [2:0] d,
                                            input logic [2:0] s1, input logic [2:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one instruction through all four states with in_valid for one cycle.
    task automatic applyStimulus(input string tag, input logic [11:0] ins,
                                 input logic expWe, input logic [2:0] expWad,
                                 input logic [3:0] expWd, input logic [3:0] expRes,
                                 input logic expC, input logic expZ);
        int we0;
        int dn0;
        @(negedge clk);
        checkOutput({tag, ":ready"}, 32'(in_ready), 32'd1);
        we0      = weCount;
        dn0      = doneCount;
        in_valid = 1'b1;
        instr    = ins;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        instr    = 12'hFFF;
        checkOutput({tag, ":read_ad1"}, 32'(RF_ad1), 32'(ins[5:3]));
        checkOutput({tag, ":read_ad2"}, 32'(RF_ad2), 32'(ins[2:0]));
        checkOutput({tag, ":read_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, ":read_notready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput({tag, ":exec_we"}, 32'(RF_we), 32'(expWe));
        checkOutput({tag, ":exec_done"}, 32'(done), 32'd0);
        if (expWe) begin
            checkOutput({tag, ":exec_wad"}, 32'(RF_wad), 32'(expWad));
            checkOutput({tag, ":exec_wd"}, 32'(RF_wd), 32'(expWd));
        end
        @(negedge clk);
        checkOutput({tag, ":done_pulse"}, 32'(done), 32'd1);
        checkOutput({tag, ":done_we"}, 32'(RF_we), 32'd0);
        checkOutput({tag, ":result"}, 32'(result), 32'(expRes));
        checkOutput({tag, ":carry"}, 32'(carry), 32'(expC));
        checkOutput({tag, ":zero"}, 32'(zero), 32'(expZ));
        @(negedge clk);
        checkOutput({tag, ":idle_done"}, 32'(done), 32'd0);
        checkOutput({tag, ":idle_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, ":we_count"}, 32'(weCount - we0), 32'(expWe));
        checkOutput({tag, ":done_count"}, 32'(doneCount - dn0), 32'd1);
        if (expWe) checkOutput({tag, ":rf_commit"}, 32'(rfMem[expWad]), 32'(expWd));
    endtask

    initial begin
        int acc0;
        int we0;
        int dn0;
        checks      = 0;
        failures    = 0;
        weCount     = 0;
        doneCount   = 0;
        acceptCount = 0;
        cycleCount  = 0;
        lastAccept  = 0;
        prevAccept  = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        instr       = 12'h000;
        loadEn      = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        loadEn = 1'b0;
        checkOutput("rst:we", 32'(RF_we), 32'd0);
        checkOutput("rst:wd", 32'(RF_wd), 32'd0);
        checkOutput("rst:wad", 32'(RF_wad), 32'd0);
        checkOutput("rst:ad1", 32'(RF_ad1), 32'd0);
        checkOutput("rst:ad2", 32'(RF_ad2), 32'd0);
        checkOutput("rst:done", 32'(done), 32'd0);
        checkOutput("rst:busy", 32'(busy), 32'd0);
        checkOutput("rst:result", 32'(result), 32'd0);
        checkOutput("rst:carry", 32'(carry), 32'd0);
        checkOutput("rst:zero", 32'(zero), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst:ready", 32'(in_ready), 32'd1);

        applyStimulus("ldi9", mkInstr(3'b111, 3'd5, 3'd1, 3'd1), 1'b1, 3'd5, 4'd9, 4'd9, 1'b0, 1'b0);
        applyStimulus("add12", mkInstr(3'b001, 3'd6, 3'd5, 3'd3), 1'b1, 3'd6, 4'd12, 4'd12, 1'b0, 1'b0);
        applyStimulus("ldi15", mkInstr(3'b111, 3'd5, 3'd1, 3'd7), 1'b1, 3'd5, 4'd15, 4'd15, 1'b0, 1'b0);
        applyStimulus("addovf", mkInstr(3'b001, 3'd6, 3'd5, 3'd1), 1'b1, 3'd6, 4'd0, 4'd0, 1'b1, 1'b1);
        applyStimulus("sub", mkInstr(3'b010, 3'd7, 3'd1, 3'd2), 1'b1, 3'd7, 4'hF, 4'hF, 1'b1, 1'b0);
        applyStimulus("xor", mkInstr(3'b101, 3'd7, 3'd7, 3'd7), 1'b1, 3'd7, 4'd0, 4'd0, 1'b0, 1'b1);

        // Back-to-back with in_valid held: OR r4,r1,r2 then MOV r3,r5
        @(negedge clk);
        acc0     = acceptCount;
        we0      = weCount;
        dn0      = doneCount;
        in_valid = 1'b1;
        instr    = mkInstr(3'b100, 3'd4, 3'd1, 3'd2);
        @(posedge clk);
        @(negedge clk);
        instr = mkInstr(3'b110, 3'd3, 3'd5, 3'd0);
        checkOutput("b2b:ready_read", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("b2b:ready_exec", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("b2b:ready_done", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("b2b:ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        checkOutput("b2b:accepts", 32'(acceptCount - acc0), 32'd2);
        checkOutput("b2b:gap", 32'(lastAccept - prevAccept), 32'd4);
        checkOutput("b2b:writes", 32'(weCount - we0), 32'd2);
        checkOutput("b2b:dones", 32'(doneCount - dn0), 32'd2);
        checkOutput("b2b:r4", 32'(rfMem[4]), 32'd3);
        checkOutput("b2b:r3", 32'(rfMem[3]), 32'd15);
        checkOutput("b2b:result", 32'(result), 32'd15);

        // Reset in the middle of EXEC of ADD r4,r1,r3 (would write 4)
        @(negedge clk);
        dn0      = doneCount;
        in_valid = 1'b1;
        instr    = mkInstr(3'b001, 3'd4, 3'd1, 3'd3);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort:we_before", 32'(RF_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        checkOutput("abort:we", 32'(RF_we), 32'd0);
        checkOutput("abort:wd", 32'(RF_wd), 32'd0);
        checkOutput("abort:wad", 32'(RF_wad), 32'd0);
        checkOutput("abort:ad1", 32'(RF_ad1), 32'd0);
        checkOutput("abort:busy", 32'(busy), 32'd0);
        checkOutput("abort:result", 32'(result), 32'd0);
        checkOutput("abort:carry", 32'(carry), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort:ready", 32'(in_ready), 32'd1);
        checkOutput("abort:r4", 32'(rfMem[4]), 32'd3);
        for (int i = 0; i < 3; i++) @(negedge clk);
        checkOutput("abort:no_done", 32'(doneCount - dn0), 32'd0);
        checkOutput("abort:idle", 32'(busy), 32'd0);

        // ADD giving 3, then NOP must leave result and flags alone
        applyStimulus("add3", mkInstr(3'b001, 3'd4, 3'd1, 3'd2), 1'b1, 3'd4, 4'd3, 4'd3, 1'b0, 1'b0);
        applyStimulus("nop", mkInstr(3'b000, 3'd2, 3'd1, 3'd2), 1'b0, 3'd0, 4'd0, 4'd3, 1'b0, 1'b0);
        checkOutput("nop:r2", 32'(rfMem[2]), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
